// File: rtl/operand_recover_6bit.sv
// Bit-serial recovery of the third addend: C = (S - A - B) mod 64, one bit per clock, LSB first.
// Optional underflow output is compiled in with `define RECOVER_UNDERFLOW_FLAG_EN.
module operand_recover_6bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] S,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] C,
  output logic       busy
`ifdef RECOVER_UNDERFLOW_FLAG_EN
  ,
  output logic       underflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [5:0] s_reg, a_reg, b_reg, c_reg, c_next;
  logic [1:0] borrow_reg, borrow_calc;
  logic [2:0] index_reg;
  logic [2:0] diff_bias;
  logic       bit_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (index_reg == 3'd5) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  assign C = c_reg;

  // d = S[i]-A[i]-B[i]-borrow lies in -4..1; biasing by 4 keeps it unsigned (0..5).
  // Then C[i] = bias[0] and borrow = (C[i]-d)/2 = 2 - bias[2:1].
  always_comb begin
    diff_bias   = 3'd4 + {2'b00, s_reg[index_reg]} - {2'b00, a_reg[index_reg]}
                - {2'b00, b_reg[index_reg]} - {1'b0, borrow_reg};
    bit_c       = diff_bias[0];
    borrow_calc = 2'd2 - diff_bias[2:1];
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_c_bit
      assign c_next[gi] = (index_reg == 3'(gi)) ? bit_c : c_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      borrow_reg <= '0;
      index_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            s_reg      <= S;
            a_reg      <= A;
            b_reg      <= B;
            c_reg      <= '0;
            borrow_reg <= '0;
            index_reg  <= '0;
          end
        end
        RUN: begin
          c_reg      <= c_next;
          borrow_reg <= borrow_calc;
          index_reg  <= index_reg + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RECOVER_UNDERFLOW_FLAG_EN
  logic underflow_reg;

  // Final borrow out of bit 5 means S < A + B.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (state_reg == RUN && index_reg == 3'd5) begin
      underflow_reg <= (borrow_calc != 2'd0);
    end
  end

  assign underflow = underflow_reg;
`endif

endmodule

// File: doc/operand_recover_6bit.md
OPERAND_RECOVER_6BIT -- requirements
Module: operand_recover_6bit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port in_valid, input, 1 bit: the S/A/B operand set is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-005 SHALL have port S, input, 6 bits: three-operand sum, modulo 64.
REQ-006 SHALL have ports A and B, input, 6 bits each: two known addends.
REQ-007 SHALL have port out_valid, output, 1 bit: C is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts C.
REQ-009 SHALL have port C, output, 6 bits: recovered third addend, C = (S - A - B) mod 64.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 IDLE: in_ready=1; on an edge with in_valid=1, SHALL latch S, A and B, clear the 2-bit borrow and the 3-bit bit index, and go to RUN.
REQ-013 RUN: each edge SHALL process bit i = index, LSB first.
- Computes d = S[i] - A[i] - B[i] - borrow.
- Writes C[i] = d mod 2.
- Sets borrow = (C[i] - d) / 2; borrow range is 0..2.
- Increments index.
REQ-014 SHALL leave RUN on the edge that processes bit 5 and enter DONE; latency is accept edge plus 6 edges, so out_valid rises after the 6th edge following acceptance.
REQ-015 DONE: out_valid=1 and C SHALL hold stable until an edge with out_ready=1, then the block SHALL return to IDLE.
REQ-016 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-017 There SHALL be no IDLE accept in the same cycle as the DONE handshake; the minimum input-to-input period is 8 cycles with out_ready held high.
REQ-018 C SHALL show partial results during RUN, but consumers SHALL qualify C with out_valid only.
REQ-019 All arithmetic SHALL wrap modulo 64, with no saturation.
REQ-020 busy SHALL equal (state != IDLE).

Reset
REQ-021 On an edge with rst=1, the block SHALL enter IDLE from any state, including mid-RUN and DONE, and SHALL discard the operation in progress.
REQ-022 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, C=0, borrow=0, index=0, and underflow=0 when that port is compiled in.
REQ-023 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-024 Macro RECOVER_UNDERFLOW_FLAG_EN, when defined, SHALL add output port underflow (1 bit).
- underflow equals (final borrow != 0), i.e. S < A + B as unsigned integers.
- It is valid with out_valid and held with C.
REQ-025 Without RECOVER_UNDERFLOW_FLAG_EN, the underflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 S=10, A=3, B=4, out_ready=1 -> C=3 with out_valid after 6 edges past accept; underflow=0.
REQ-027 S=0, A=1, B=1 -> C=62; underflow=1 (macro defined).
REQ-028 S=63, A=63, B=63 -> C=1, underflow=1; S=63, A=0, B=0 -> C=63, underflow=0.
REQ-029 out_ready=0 for 5 cycles in DONE -> C and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-030 rst=1 at RUN index 3 -> next cycle: IDLE, out_valid=0, C=0; a following operand set S=20, A=5, B=5 -> C=10.
REQ-031 Two back-to-back sets (S=7, A=1, B=2) then (S=0, A=0, B=63) with out_ready=1 -> C=4 then C=1, with accepts 8 cycles apart.
